// File: rtl/ds_syn_accum_pkg.sv
// Shared Q0.14 constants and FSM state type for the DS neuron array.
package ds_snn_pkg;

    localparam int DS_W    = 14;
    localparam int DS_FRAC = 14;

    localparam logic [DS_W-1:0] DS_SAT_MAX = DS_W'((1 << DS_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        DECAY,
        SCAN,
        OUT
    } ds_syn_state_t;

endpackage

// File: rtl/ds_syn_accum_if.sv
// Weight programming bus for the synaptic accumulator.
interface ds_syn_accum_if #(
    parameter int W  = 14,
    parameter int AW = 3
);

    logic          weight_we;
    logic [AW-1:0] weight_addr;
    logic [W-1:0]  weight_data;

    modport master (
        output weight_we,
        output weight_addr,
        output weight_data
    );

    modport slave (
        input weight_we,
        input weight_addr,
        input weight_data
    );

endinterface

// File: rtl/ds_weight_rf.sv
// Synaptic weight register file: one sync write port, one async read port.
module ds_weight_rf #(
    parameter int N_IN = 8,
    parameter int W    = 14,
    parameter int AW   = 3
) (
    input  logic          clk_in,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [N_IN];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_IN; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ds_syn_accum.sv
// Synaptic current generator: per-frame decay, then sequential weight scan.
module ds_syn_accum
    import ds_snn_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int W    = DS_W,
    parameter int AW   = 3
) (
    input  logic            clk_in,
    input  logic            reset_n,
    input  logic            frame_en,
    input  logic [N_IN-1:0] pre_spike,
    input  logic [W-1:0]    decay,
    ds_syn_accum_if.slave   wr,
    output logic [W-1:0]    syn_o,
    output logic            syn_valid,
    output logic            busy
);

    localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

    ds_syn_state_t   state;
    ds_syn_state_t   nxt;
    logic [AW-1:0]   idx;
    logic [W-1:0]    acc;
    logic [W-1:0]    w_rd;
    logic [N_IN-1:0] pending;
    logic [N_IN-1:0] snap;
    logic [2*W-1:0]  prod;
    logic [W:0]      sum;
    logic [W-1:0]    acc_sat;

    ds_weight_rf #(
        .N_IN (N_IN),
        .W    (W),
        .AW   (AW)
    ) u_rf (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .we      (wr.weight_we),
        .wr_addr (wr.weight_addr),
        .wr_data (wr.weight_data),
        .rd_addr (idx),
        .rd_data (w_rd)
    );

    always_comb begin
        prod    = {{W{1'b0}}, acc} * {{W{1'b0}}, decay};
        sum     = {1'b0, acc} + {1'b0, w_rd};
        acc_sat = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // A frame always runs to OUT; frame_en is only consulted at its edges.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (frame_en) nxt = DECAY;
            DECAY:   nxt = SCAN;
            SCAN:    if (idx == LAST) nxt = OUT;
            OUT:     nxt = frame_en ? DECAY : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            acc       <= '0;
            pending   <= '0;
            snap      <= '0;
            syn_o     <= '0;
            syn_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy      <= (nxt != IDLE);
            syn_valid <= (state == OUT);
            // Same-cycle spikes bypass pending so none fall between frames.
            if (state == DECAY) begin
                snap    <= pending | pre_spike;
                pending <= '0;
            end else begin
                pending <= pending | pre_spike;
            end
            unique case (state)
                DECAY: begin
                    acc <= prod[2*W-1:W];
                    idx <= '0;
                end
                SCAN: begin
                    if (snap[idx]) acc <= acc_sat;
                    idx <= idx + 1'b1;
                end
                OUT:     syn_o <= acc;
                default: ;
            endcase
        end
    end

endmodule
